// File: rtl/seq_pkg.sv
// Shared defaults and state encoding for the serial sequence generator/detector pair.
package seq_pkg;

  localparam int DEF_PATTERN_W = 4;
  localparam int DEF_CNT_W     = 8;
  localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN_RESET = 4'b1011;

  // FILL: fewer than PATTERN_W fresh bits held; ARMED: a full window is present.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/seq_history.sv
// Bit history shift register with a saturating fill counter tracking how many
// of the held bits are fresh (received since the last clear/restart).
module seq_history #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift,        // consume bit_in this cycle
  input  logic         bit_in,
  input  logic         clear,        // wipe history and fill (reconfiguration)
  input  logic         restart,      // with shift: keep history, fill back to 0
  output logic [W-1:0] history_next, // window as it will look if bit_in is shifted in
  output logic         full_next     // this shift completes a window of W fresh bits
);

  localparam int FW = $clog2(W + 1);

  logic [W-1:0]  history;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_inc;

  // Look-ahead values for the comparator in the parent.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    history_next = {history[W-2:0], bit_in};
    fill_inc     = (fill == FW'(W)) ? fill : fill + FW'(1);
    full_next    = shift && (fill_inc == FW'(W));
  end

  // History and fill registers; clear outranks shift.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= history_next;
      fill    <= restart ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/sequence_detector.sv
// Serial bit-stream pattern detector with overlapping / non-overlapping modes,
// a one-cycle match pulse and a saturating match counter.
module sequence_detector
  import seq_pkg::*;
#(
  parameter int                   PATTERN_W     = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN_RESET = DEF_PATTERN_RESET,
  parameter int                   CNT_W         = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic                 cfg_overlap,
  input  logic                 clear_count,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic                 armed
);

  seq_state_e           state_q, state_d;
  logic [PATTERN_W-1:0] pattern_q;
  logic                 overlap_q;
  logic [PATTERN_W-1:0] history_next;
  logic                 full_next;
  logic                 shift;
  logic                 hit;
  logic                 restart;

  // A configuration load drops any bit offered in the same cycle.
  assign shift   = bit_valid && !cfg_load;
  assign hit     = full_next && (history_next == pattern_q);
  assign restart = hit && !overlap_q;

  seq_history #(.W(PATTERN_W)) u_history (
    .clk          (clk),
    .reset        (reset),
    .shift        (shift),
    .bit_in       (bit_in),
    .clear        (cfg_load),
    .restart      (restart),
    .history_next (history_next),
    .full_next    (full_next)
  );

  // Pattern and mode registers, reloaded by cfg_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= PATTERN_RESET;
      overlap_q <= 1'b1;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      overlap_q <= cfg_overlap;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // FSM next state: armed while the window is full; a non-overlap match empties it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL:  if (full_next && !restart)  state_d = ST_ARMED;
      ST_ARMED: if (cfg_load || restart)    state_d = ST_FILL;
      default:                              state_d = ST_FILL;
    endcase
  end

  assign armed = (state_q == ST_ARMED);

  // Match pulse and saturating counter; a clear coinciding with a match leaves 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= hit;
      if (clear_count)
        match_count <= {{(CNT_W-1){1'b0}}, hit};
      else if (hit && (match_count != {CNT_W{1'b1}}))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Scoreboard bench for sequence_detector (PATTERN_W = 4, CNT_W = 8).
// Stimulus pushes each expected match (edge number and count) into a queue;
// the monitor pops one entry for every match pulse it observes.
module tb_sequence_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       bit_in;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       clear_count;
  logic       match;
  logic [7:0] match_count;
  logic       armed;

  typedef struct {
    int edge_no;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   exp_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sequence_detector #(
    .PATTERN_W     (4),
    .PATTERN_RESET (4'b1011),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .clear_count (clear_count),
    .match       (match),
    .match_count (match_count),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every observed match pulse must correspond to the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && match) begin
      if (sb.size() == 0) begin
        check("spurious_match", int'(match), 0);
      end else begin
        e = sb.pop_front();
        check("match_edge", edge_cnt, e.edge_no);
        check("match_count_at_pulse", int'(match_count), e.cnt);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid   = 1'b0;
      bit_in      = 1'b0;
      cfg_load    = 1'b0;
      clear_count = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input logic m, input logic clr = 1'b0);
    exp_t e;
    @(negedge clk);
    bit_valid   = 1'b1;
    bit_in      = b;
    cfg_load    = 1'b0;
    clear_count = clr;
    if (m) begin
      if (clr) exp_cnt = 1;
      else if (exp_cnt < 255) exp_cnt++;
      e.edge_no = edge_cnt + 1;
      e.cnt     = exp_cnt;
      sb.push_back(e);
    end else if (clr) begin
      exp_cnt = 0;
    end
  endtask

  // bits/flags are sent MSB first: bits[n-1] is the first bit on the wire.
  task automatic send_seq(input logic [15:0] bits, input logic [15:0] flags, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], flags[i]);
  endtask

  task automatic load_cfg(input logic [3:0] pat, input logic ovl, input logic clr,
                          input logic valid = 1'b0, input logic b = 1'b0);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    clear_count = clr;
    bit_valid   = valid;
    bit_in      = b;
    if (clr) exp_cnt = 0;
  endtask

  // Let outstanding pulses drain, then require that every expected match was seen.
  task automatic drain(input string name);
    idle(3);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps[6] = '{0, 1, 2, 3, 0, 2};

    reset       = 1'b1;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0;
    clear_count = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Reset defaults
    idle(1);
    check("reset_match", int'(match), 0);
    check("reset_count", int'(match_count), 0);
    check("reset_armed", int'(armed), 0);

    // Default pattern 1011, overlapping
    send_seq(16'b1011, 16'b0001, 4);
    idle(1);
    check("dflt_armed", int'(armed), 1);
    check("dflt_count", int'(match_count), 1);
    drain("dflt_sb_empty");

    // Overlap mode: matches after bits 4 and 7
    load_cfg(4'b1011, 1'b1, 1'b1);
    idle(1);
    check("ovl_cleared", int'(match_count), 0);
    send_seq(16'b1011011, 16'b0001001, 7);
    drain("ovl_sb_empty");
    check("ovl_count", int'(match_count), 2);

    // Non-overlap mode: one match, window empties, trailing 1 gives history 0111
    load_cfg(4'b1011, 1'b0, 1'b1);
    send_seq(16'b1011, 16'b0001, 4);
    idle(1);
    check("novl_armed_drop", int'(armed), 0);
    send_seq(16'b0111, 16'b0000, 4);
    idle(1);
    check("novl_armed_refill", int'(armed), 1);
    drain("novl_sb_empty");
    check("novl_count", int'(match_count), 1);

    // Pattern 1111, overlapping, with bit_valid gaps of 0..3 cycles
    load_cfg(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, i >= 3);
      if (gaps[i] > 0) idle(gaps[i]);
    end
    drain("gap_sb_empty");
    check("gap_count", int'(match_count), 3);

    // clear_count on the completing bit leaves the count at 1
    load_cfg(4'b1011, 1'b1, 1'b1);
    send_seq(16'b1011, 16'b0001, 4);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1);
    idle(1);
    check("clr_with_match", int'(match_count), 1);

    // cfg_load with a would-be completing bit: bit dropped, window empty
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    load_cfg(4'b1011, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("load_armed", int'(armed), 0);
    send_seq(16'b101, 16'b000, 3);
    idle(1);
    check("load_fill_zero", int'(armed), 0);
    send_bit(1'b1, 1'b1);
    drain("load_sb_empty");
    check("load_count", int'(match_count), 2);

    // Saturation: 300 matches on 1111
    load_cfg(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 303; i++) send_bit(1'b1, i >= 3);
    drain("sat_sb_empty");
    check("sat_count", int'(match_count), 255);

    // Asynchronous reset mid-stream
    load_cfg(4'b1111, 1'b1, 1'b0);
    send_seq(16'b101, 16'b000, 3);
    @(negedge clk);
    bit_valid = 1'b0;
    #2 reset = 1'b1;
    exp_cnt = 0;
    #1;
    check("async_rst_count", int'(match_count), 0);
    check("async_rst_armed", int'(armed), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    send_bit(1'b1, 1'b0);
    idle(2);
    check("post_rst_count", int'(match_count), 0);
    send_seq(16'b011011, 16'b001001, 6);
    drain("post_rst_sb_empty");
    check("post_rst_pattern", int'(match_count), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
